// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: parallel word in over valid/ready, one bit per clock on x.
// Optional 0,1,1 frame preamble compiled in with `define PREAMBLE_EN.
module serial_pattern_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // One-hot so any illegal pattern falls into the default arm.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
`ifdef PREAMBLE_EN
        S_PRE  = 4'b0010,
`endif
        S_DATA = 4'b0100,
        S_GAP  = 4'b1000
    } state_e;

`ifdef PREAMBLE_EN
    localparam state_e START = S_PRE;
`else
    localparam state_e START = S_DATA;
`endif
    localparam state_e AFTER_DATA = (GAP > 0) ? S_GAP : S_IDLE;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gap_last;
`ifdef PREAMBLE_EN
    logic [1:0]       pre_q, pre_d;
`endif

    assign ready = (state_q == S_IDLE);
    assign x     = x_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; unknown encodings return to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = valid ? START : S_IDLE;
`ifdef PREAMBLE_EN
            S_PRE:   state_d = (pre_q == 2'd0) ? S_DATA : S_PRE;
`endif
            S_DATA:  state_d = (cnt_q != '0) ? S_DATA : AFTER_DATA;
            S_GAP:   state_d = gap_last ? S_IDLE : S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Shift register and bit counter: load on accept, advance in DATA.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = LAST;
            if (valid) sh_d = data_in;
        end else if (state_q == S_DATA) begin
            sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b1}
                             : {1'b1, sh_q[WIDTH-1:1]};
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
    end

`ifdef PREAMBLE_EN
    // Preamble counter runs 2,1,0; the first preamble cycle drives 0.
    always_comb begin
        pre_d = pre_q;
        if (state_q == S_IDLE)                   pre_d = 2'd2;
        else if (state_q == S_PRE && pre_q != 0) pre_d = pre_q - 2'd1;
    end
`endif

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        x_d    = 1'b1;
        done_d = 1'b0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_DATA: begin
                x_d    = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
                done_d = (cnt_d == '0);
            end
`ifdef PREAMBLE_EN
            S_PRE:   x_d = (pre_d != 2'd2);
`endif
            default: x_d = 1'b1;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            x_q    <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef PREAMBLE_EN
            pre_q  <= 2'd0;
`endif
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef PREAMBLE_EN
            pre_q  <= pre_d;
`endif
        end
    end

    generate
        if (GAP > 0) begin : g_gap
            localparam int unsigned GW = $clog2(GAP + 1);
            logic [GW-1:0] gcnt_q;
            // Gap counter: preloaded outside GAP, counts down inside it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                gcnt_q <= '0;
                else if (state_q != S_GAP) gcnt_q <= GW'(GAP - 1);
                else if (gcnt_q != '0)     gcnt_q <= gcnt_q - GW'(1);
            end
            assign gap_last = (gcnt_q == '0);
        end else begin : g_nogap
            assign gap_last = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three configurations checked every cycle
// against a frame-queue model, plus directed literal frames and async reset.
module tb_serial_pattern_tx;

`ifdef PREAMBLE_EN
    localparam int P = 3;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid [3];
    logic [7:0] din [3];
    logic       x_w [3];
    logic       done_w [3];
    logic       busy_w [3];
    logic       ready_w [3];
    int         n_tests = 0;
    int         n_fail = 0;
    bit         running = 1'b1;

    always #5 clk = ~clk;

    function automatic logic [3:0] st(input int g);
        return {x_w[g], done_w[g], busy_w[g], ready_w[g]};
    endfunction

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t xdbr got=%b want=%b",
                     nm, $time, got, exp);
        end
    endtask

    // Expected {x,done,busy,ready} in cycle c after an accept of word w.
    function automatic logic [3:0] dir_exp(input int c, input logic [7:0] w,
                                           input int wd, input bit msb,
                                           input int gp);
        int i;
        i = c - P;
        if (c <= P) return {c != 1, 3'b010};
        if (i <= wd) return {msb ? w[wd-i] : w[i-1], i == wd, 2'b10};
        if (i <= wd + gp) return 4'b1010;
        return 4'b1001;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int W   = (g == 2) ? 4 : 8;
        localparam bit MSB = (g == 1) ? 1'b0 : 1'b1;
        localparam int GP  = (g == 0) ? 1 : ((g == 1) ? 2 : 0);

        serial_pattern_tx #(.WIDTH(W), .MSB_FIRST(MSB), .GAP(GP)) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_in (din[g][W-1:0]),
            .valid   (valid[g]),
            .ready   (ready_w[g]),
            .x       (x_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g])
        );

        logic [3:0] q[$];
        logic [3:0] cur = 4'b1001;

        // Model: a frame is the list of per-cycle outputs queued on accept.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                cur = 4'b1001;
            end else begin
                if (cur[0] && valid[g]) begin
                    for (int p = 0; p < P; p++)
                        q.push_back({p != 0, 3'b010});
                    for (int i = 0; i < W; i++)
                        q.push_back({din[g][MSB ? W-1-i : i],
                                     i == W-1, 2'b10});
                    for (int i = 0; i < GP; i++)
                        q.push_back(4'b1010);
                end
                if (q.size() > 0) cur = q.pop_front();
                else              cur = 4'b1001;
            end
        end

        always @(negedge clk) begin
            if (running) begin
                n_tests++;
                if (st(g) !== cur) begin
                    n_fail++;
                    $display("FAIL model[%0d] t=%0t xdbr got=%b want=%b",
                             g, $time, st(g), cur);
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            valid[g] = 1'b0;
            din[g]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) chk("reset_state", st(g), 4'b1001);
        rst_n = 1'b1;

        // Directed: 0x0F MSB first, 0x0F LSB first, 4-bit 0x9 with no gap.
        @(negedge clk);
        for (int g = 0; g < 3; g++) valid[g] = 1'b1;
        din[0] = 8'h0F;
        din[1] = 8'h0F;
        din[2] = 8'h09;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) valid[g] = 1'b0;
        for (int c = 1; c <= 11 + P; c++) begin
            @(negedge clk);
            chk("dir_msb_0f", st(0), dir_exp(c, 8'h0F, 8, 1'b1, 1));
            chk("dir_lsb_0f", st(1), dir_exp(c, 8'h0F, 8, 1'b0, 2));
            chk("dir_w4_9",   st(2), dir_exp(c, 8'h09, 4, 1'b1, 0));
        end

        // Async reset during the 4th data bit of 0xA5.
        @(negedge clk);
        valid[0] = 1'b1;
        din[0]   = 8'hA5;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        repeat (P + 4) @(negedge clk);
        chk("a5_bit3", st(0), dir_exp(P + 4, 8'hA5, 8, 1'b1, 1));
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) chk("async_reset", st(g), 4'b1001);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 0xFF after reset; a 0x55 pulse while busy must be dropped.
        @(negedge clk);
        valid[0] = 1'b1;
        din[0]   = 8'hFF;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        for (int c = 1; c <= 10 + P; c++) begin
            @(negedge clk);
            chk("post_reset_ff", st(0), dir_exp(c, 8'hFF, 8, 1'b1, 1));
            valid[0] = (c == 3);
            din[0]   = 8'h55;
        end

        // Random traffic, alternating held-valid and sparse-valid phases.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                valid[g] = ((cyc / 500) % 2 == 0) ? 1'b1
                                                  : ($urandom % 4 == 0);
                din[g]   = 8'($urandom);
            end
        end

        @(negedge clk);
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
